// File: rtl/load_store_unit.sv
// Sub-word load/store sequencer between the datapath and a word-wide memory.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StRdIssue   = 3'd1;
    localparam logic [2:0] StRdCapture = 3'd2;
    localparam logic [2:0] StWr        = 3'd3;
    localparam logic [2:0] StDone      = 3'd4;

    logic [2:0]            state;
    logic                  lat_write;
    logic [1:0]            lat_size;
    logic                  lat_unsigned;
    logic [1:0]            lat_off;
    logic [15:0]           lat_wdata;

    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] load_data;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;

    assign req_ready = (state == StIdle) && !rst;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

    // Read word with the addressed lane(s) replaced by the latched store data.
    always_comb begin
        merged = mem_rdata;
        case (lat_size)
            2'b00:   merged[{lat_off, 3'b000} +: 8] = lat_wdata[7:0];
            2'b01:   merged[{lat_off[1], 4'b0000} +: 16] = lat_wdata[15:0];
            default: merged = mem_rdata;
        endcase
    end

    always_comb begin
        lane_byte = mem_rdata[{lat_off, 3'b000} +: 8];
        lane_half = mem_rdata[{lat_off[1], 4'b0000} +: 16];
        case (lat_size)
            2'b00:   load_data = {{(DATA_WIDTH-8){lane_byte[7] & ~lat_unsigned}}, lane_byte};
            2'b01:   load_data = {{(DATA_WIDTH-16){lane_half[15] & ~lat_unsigned}}, lane_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            mem_addr     <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            lat_write    <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_off      <= 2'b00;
            lat_wdata    <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        lat_write    <= req_write;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_off      <= req_addr[1:0];
                        lat_wdata    <= req_wdata[15:0];
                        mem_addr     <= req_addr[ADDR_WIDTH+1:2];
                        resp_rdata   <= '0;
                        mem_we       <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state      <= StDone;
                        end else
`endif
                        if (req_write && req_size[1]) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= req_wdata;
                            state     <= StWr;
                        end else begin
                            state <= StRdIssue;
                        end
                    end
                end
                StRdIssue: state <= StRdCapture;
                StRdCapture: begin
                    // Loads also pass through StWr so their response lines up with stores.
                    if (lat_write) begin
                        mem_wdata <= merged;
                        mem_we    <= 1'b1;
                    end else begin
                        resp_rdata <= load_data;
                    end
                    state <= StWr;
                end
                StWr: begin
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= StDone;
                end
                StDone: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, randomized traffic
// against a lane-level reference model, reset-abort and back-to-back sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Registered memory with a backdoor port used only for initialisation.
    logic [31:0] mem [256];
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [31:0] bd_data;
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_we && !rst) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int          we_cnt = 0;
    int          resp_cnt = 0;
    logic [31:0] resp_q [$];
    always @(negedge clk) begin
        if (mem_we) we_cnt = we_cnt + 1;
        if (resp_valid) begin
            resp_cnt = resp_cnt + 1;
            resp_q.push_back(resp_rdata);
        end
    end

    logic [31:0] ref_mem [256];
    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(logic [31:0] word, logic [1:0] sz, logic u,
                                               logic [1:0] off);
        longint v;
        int bits;
        int sh;
        if (sz[1]) return word;
        bits = (sz == 2'b00) ? 8 : 16;
        sh = (sz == 2'b00) ? 8 * int'(off) : 16 * int'(off[1]);
        v = (longint'(word) >> sh) & ((longint'(1) << bits) - 1);
        if (!u && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(logic [31:0] old, logic [1:0] sz,
                                                logic [1:0] off, logic [31:0] data);
        logic [31:0] r;
        int n;
        int base;
        if (sz[1]) return data;
        r = old;
        n = (sz == 2'b00) ? 1 : 2;
        base = (sz == 2'b00) ? int'(off) : 2 * int'(off[1]);
        for (int i = 0; i < n; i++) r[8*(base+i) +: 8] = data[8*i +: 8];
        return r;
    endfunction

    function automatic logic model_mis(logic [1:0] sz, logic [1:0] off);
`ifdef LSU_MISALIGN_TRAP_EN
        return (sz == 2'b01 && off[0]) || (sz[1] && off != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_req(input string nm, input logic w, input logic [1:0] sz, input logic u,
                           input logic [9:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_er, input int exp_lat, input int exp_we);
        logic [31:0] rd;
        logic er;
        int lat;
        int t;
        int we0;
        logic pulse_hi;
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk($sformatf("%s.ready", nm), 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        we0 = we_cnt;
        #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = 10'($urandom); req_wdata = $urandom;
        lat = -1; rd = '0; er = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (resp_valid) begin
                lat = n; rd = resp_rdata; er = resp_err;
                break;
            end
        end
        @(posedge clk); #1;
        pulse_hi = resp_valid;
        t = 0;
        while (!req_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        @(negedge clk); #1;
        chk($sformatf("%s.rdata", nm), rd, exp_rd);
        chk($sformatf("%s.err", nm), 32'(er), 32'(exp_er));
        chk($sformatf("%s.latency", nm), 32'(lat), 32'(exp_lat));
        chk($sformatf("%s.pulse_len", nm), 32'(pulse_hi), 32'd0);
        chk($sformatf("%s.we_cycles", nm), 32'(we_cnt - we0), 32'(exp_we));
    endtask

    // Computes expectations from the model, runs the request, then updates/compares memory.
    task automatic run_model(input string nm, input logic w, input logic [1:0] sz, input logic u,
                             input logic [7:0] word, input logic [1:0] off, input logic [31:0] wd);
        logic mis;
        logic [31:0] exp_rd;
        int exp_lat;
        mis = model_mis(sz, off);
        exp_rd = (w || mis) ? 32'd0 : model_load(ref_mem[word], sz, u, off);
        exp_lat = mis ? 0 : ((w && sz[1]) ? 1 : 3);
        run_req(nm, w, sz, u, {word, off}, wd, exp_rd, mis, exp_lat, (w && !mis) ? 1 : 0);
        if (w && !mis) ref_mem[word] = model_store(ref_mem[word], sz, off, wd);
        chk($sformatf("%s.mem", nm), mem[word], ref_mem[word]);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [9:0]  a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          we;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] old8;
        int we0;
        int rv0;
        int q0;
        int acc_edge [3];
        logic accepted;
        logic r;
        int e;
        int guard;
        logic [7:0] bw [3];
        logic [1:0] bs [3];
        logic [31:0] bexp [3];

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0,        1'b0, 1, 1};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0};
        vecs[2]  = '{1'b1, 2'b11, 1'b0, 10'h010, 32'h11223344, 32'h0,        1'b0, 1, 1};
        vecs[3]  = '{1'b1, 2'b00, 1'b0, 10'h012, 32'h555555AA, 32'h0,        1'b0, 3, 1};
        vecs[4]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0,        32'h11AA3344, 1'b0, 3, 0};
        vecs[5]  = '{1'b1, 2'b10, 1'b0, 10'h010, 32'h80FF7F01, 32'h0,        1'b0, 1, 1};
        vecs[6]  = '{1'b0, 2'b00, 1'b0, 10'h011, 32'h0,        32'h0000007F, 1'b0, 3, 0};
        vecs[7]  = '{1'b0, 2'b00, 1'b0, 10'h012, 32'h0,        32'hFFFFFFFF, 1'b0, 3, 0};
        vecs[8]  = '{1'b0, 2'b00, 1'b1, 10'h012, 32'h0,        32'h000000FF, 1'b0, 3, 0};
        vecs[9]  = '{1'b0, 2'b01, 1'b0, 10'h012, 32'h0,        32'hFFFF80FF, 1'b0, 3, 0};
        vecs[10] = '{1'b0, 2'b01, 1'b1, 10'h012, 32'h0,        32'h000080FF, 1'b0, 3, 0};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[11] = '{1'b0, 2'b10, 1'b0, 10'h013, 32'h0,        32'h0,        1'b1, 0, 0};
`else
        vecs[11] = '{1'b0, 2'b10, 1'b0, 10'h013, 32'h0,        32'h80FF7F01, 1'b0, 3, 0};
`endif

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        for (int i = 0; i < 256; i++) begin
            bd_we = 1'b1; bd_addr = 8'(i); bd_data = $urandom; ref_mem[i] = bd_data;
            @(posedge clk); #1;
        end
        bd_we = 1'b0;
        chk("reset.req_ready", 32'(req_ready), 32'd0);
        chk("reset.resp_valid", 32'(resp_valid), 32'd0);
        chk("reset.resp_err", 32'(resp_err), 32'd0);
        chk("reset.resp_rdata", resp_rdata, 32'd0);
        chk("reset.mem_we", 32'(mem_we), 32'd0);
        chk("reset.mem_wdata", mem_wdata, 32'd0);
        chk("reset.mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset.req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a,
                    vecs[i].wd, vecs[i].rd, vecs[i].er, vecs[i].lat, vecs[i].we);
            if (vecs[i].w && !model_mis(vecs[i].sz, vecs[i].a[1:0]))
                ref_mem[vecs[i].a[9:2]] = model_store(ref_mem[vecs[i].a[9:2]], vecs[i].sz,
                                                      vecs[i].a[1:0], vecs[i].wd);
        end
        chk("vec.word4", mem[4], 32'h80FF7F01);

        for (int i = 0; i < 150; i++) begin
            run_model($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom), 1'($urandom),
                      8'($urandom_range(0, 15)), 2'($urandom), $urandom);
        end

        // Reset lands on the RD_CAPTURE edge of a halfword store to word 8.
        old8 = mem[8];
        we0 = we_cnt;
        rv0 = resp_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 10'h020; req_wdata = 32'h0000BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("rstmid.ready_in_rst", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid.mem_we", 32'(mem_we), 32'd0);
        chk("rstmid.resp_valid", 32'(resp_valid), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("rstmid.we_cycles", 32'(we_cnt - we0), 32'd0);
        chk("rstmid.resp_pulses", 32'(resp_cnt - rv0), 32'd0);
        chk("rstmid.word8", mem[8], old8);
        chk("rstmid.req_ready", 32'(req_ready), 32'd1);

        // Back-to-back loads with req_valid held high throughout.
        bw[0] = 8'd1; bs[0] = 2'b10;
        bw[1] = 8'd2; bs[1] = 2'b00;
        bw[2] = 8'd3; bs[2] = 2'b01;
        for (int i = 0; i < 3; i++) bexp[i] = model_load(ref_mem[bw[i]], bs[i], 1'b1, 2'b00);
        q0 = resp_q.size();
        e = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            req_valid = 1'b1; req_write = 1'b0; req_size = bs[i]; req_unsigned = 1'b1;
            req_addr = {bw[i], 2'b00}; req_wdata = $urandom;
            accepted = 1'b0;
            guard = 0;
            acc_edge[i] = -100;
            while (!accepted && guard < 20) begin
                @(negedge clk);
                r = req_ready;
                @(posedge clk);
                e++;
                guard++;
                if (r) begin
                    accepted = 1'b1;
                    acc_edge[i] = e;
                end
            end
            chk($sformatf("b2b.accept%0d", i), 32'(accepted), 32'd1);
        end
        #1;
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk); #1;
        chk("b2b.gap01", 32'(acc_edge[1] - acc_edge[0]), 32'd5);
        chk("b2b.gap12", 32'(acc_edge[2] - acc_edge[1]), 32'd5);
        chk("b2b.pulses", 32'(resp_q.size() - q0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (q0 + i < resp_q.size())
                chk($sformatf("b2b.data%0d", i), resp_q[q0 + i], bexp[i]);
            else
                chk($sformatf("b2b.data%0d_missing", i), 32'hXXXXXXXX, bexp[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
